// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply,
// radix-2 restoring divide, magnitude datapath with a final sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MtHi,
    input  logic             MtLo,
    input  logic [WIDTH-1:0] Wdata,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state;
    logic                 div_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     a_raw;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 bzero_q;

    logic                 is_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh, diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    always_comb begin
        is_signed = ~Op[0];
        a_mag     = (is_signed && A[WIDTH-1]) ? -A : A;
        b_mag     = (is_signed && B[WIDTH-1]) ? -B : B;

        // Multiply step: conditional add into the upper half, then shift right with carry.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

        // Divide step: the bit shifted out of rem is kept so the trial subtract is exact.
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, b_q};
        div_next = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_fix = neg_res ? -acc : acc;
        quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            div_q   <= 1'b0;
            b_q     <= '0;
            a_raw   <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            bzero_q <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        div_q   <= Op[1];
                        b_q     <= b_mag;
                        a_raw   <= A;
                        acc     <= {{WIDTH{1'b0}}, a_mag};
                        cnt     <= CNT_W'(WIDTH);
                        neg_res <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem <= is_signed & A[WIDTH-1];
                        bzero_q <= (B == '0);
                        Busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        if (MtHi) HI <= Wdata;
                        if (MtLo) LO <= Wdata;
                    end
                end
                RUN: begin
                    acc <= div_q ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    if (!div_q) begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end else if (bzero_q) begin
                        // Divide by zero is untrapped: dividend to HI, all-ones quotient.
                        HI <= a_raw;
                        LO <= '1;
                    end else begin
                        HI <= rem_fix;
                        LO <= quot_fix;
                    end
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected HI/LO from a
// plain-arithmetic model, a monitor pops and compares on every Done pulse.
module tb_muldiv_unit;
    logic        CLK, RST, Start, MtHi, MtLo, Busy, Done;
    logic [1:0]  Op;
    logic [31:0] A, B, Wdata, HI, LO;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb_q[$];
    logic [31:0] model_hi = 0, model_lo = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .A(A), .B(B),
        .MtHi(MtHi), .MtLo(MtLo), .Wdata(Wdata),
        .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic straight from the operation definitions.
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = ua * ub;
            default: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else p = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return p;
    endfunction

    always @(negedge CLK) begin
        if (RST && Done) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got HI/LO %h_%h with nothing pending", HI, LO);
            end else begin
                check("result_hilo", {HI, LO}, sb_q.pop_front());
            end
        end
    end

    // Called at a negedge while the unit is idle; returns at the negedge of the Done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [31:0] hold_hi, hold_lo;
        logic [63:0] exp;
        int cyc;
        hold_hi = model_hi;
        hold_lo = model_lo;
        exp = ref_op(op, a, b);
        sb_q.push_back(exp);
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        Start = 1'b1; Op = op; A = a; B = b;
        MtHi = inject; MtLo = inject; Wdata = $urandom;
        @(negedge CLK);
        Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
        Op = 2'($urandom); A = $urandom; B = $urandom;
        cyc = 0;
        while (Busy && cyc < 100) begin
            cyc++;
            if (cyc == 5 && inject) begin
                Start = 1'b1; MtHi = 1'b1; MtLo = 1'b1; Wdata = $urandom;
            end else begin
                Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
            end
            if (cyc == 10) check("hold_during_run", {HI, LO}, {hold_hi, hold_lo});
            @(negedge CLK);
        end
        Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
        check("busy_cycles", 64'(cyc), 64'd33);
    endtask

    task automatic mt_write(input bit hi, input bit lo, input logic [31:0] d);
        MtHi = hi; MtLo = lo; Wdata = d;
        @(negedge CLK);
        MtHi = 1'b0; MtLo = 1'b0;
        if (hi) model_hi = d;
        if (lo) model_lo = d;
        check("mt_write", {HI, LO}, {model_hi, model_lo});
        check("mt_no_done", 64'(Done), 64'd0);
    endtask

    initial begin
        int cyc;
        RST = 1'b0; Start = 1'b0; Op = 2'b00; A = 0; B = 0;
        MtHi = 1'b0; MtLo = 1'b0; Wdata = 0;
        #12;
        check("reset_state", {HI, LO, 30'b0, Busy, Done}, 96'h0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0);
        @(negedge CLK);
        check("done_one_cycle", 64'(Done), 64'd0);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b1);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(2'b11, 32'd1234, 32'd0, 1'b0);
        run_op(2'b10, 32'hFFFFFF00, 32'd0, 1'b0);
        mt_write(1'b1, 1'b0, 32'hA5A5A5A5);
        mt_write(1'b1, 1'b1, 32'h12345678);
        mt_write(1'b0, 1'b1, 32'hDEADBEEF);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 0;
                1: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(2'($urandom), ra, rb, 1'($urandom));
            if ($urandom_range(0, 3) == 0) mt_write(1'($urandom), 1'b1, $urandom);
        end

        // Asynchronous reset in the middle of a run aborts it.
        sb_q.push_back(64'h0);
        Start = 1'b1; Op = 2'b01; A = 32'h55; B = 32'h77;
        @(negedge CLK);
        Start = 1'b0;
        repeat (9) @(negedge CLK);
        #2 RST = 1'b0;
        #1 check("async_reset_abort", {HI, LO, 30'b0, Busy, Done}, 96'h0);
        sb_q.delete();
        model_hi = 0;
        model_lo = 0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        run_op(2'b01, 32'd3, 32'd4, 1'b0);

        cyc = 0;
        while (sb_q.size() != 0 && cyc < 50) begin
            cyc++;
            @(negedge CLK);
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the architectural HI/LO registers for the execute stage.
- The execute stage is the initiator: it issues MULT/MULTU/DIV/DIVU and MTHI/MTLO requests.
- This block is the responder: it runs the operation over multiple cycles, signals Busy/Done, and presents HI/LO for MFHI/MFLO.
- Multiply is radix-2 shift-add; divide is radix-2 restoring.
- Signed operations use magnitude arithmetic followed by a sign-fix cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe; sampled only in IDLE.
- Op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  in  WIDTH  rs operand (multiplicand / dividend).
- B  in  WIDTH  rt operand (multiplier / divisor).
- MtHi  in  1  write Wdata into HI.
- MtLo  in  1  write Wdata into LO.
- Wdata  in  WIDTH  data for MTHI/MTLO.
- HI  out  WIDTH  HI register (product high half / remainder).
- LO  out  WIDTH  LO register (product low half / quotient).
- Busy  out  1  operation in progress; the execute stage stalls MFHI/MFLO and new requests while high.
- Done  out  1  one-cycle pulse in the cycle HI/LO first hold the new result.

Behaviour:
- Reset (RST=0, async):
  - HI=0, LO=0, Busy=0, Done=0.
  - FSM=IDLE, counter=0, all working registers cleared.
  - Reset mid-operation aborts it; no partial result reaches HI/LO.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - Start=1 at edge E0 latches Op and the operand magnitudes (|A|, |B| for signed ops, raw values for unsigned).
  - It records the result signs, clears the accumulator, loads counter=WIDTH, goes to RUN, and sets Busy=1.
- RUN:
  - One bit per edge; counter decrements each edge.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper accumulator, then shift the 2*WIDTH accumulator right by 1.
  - Divide: shift {rem,quot} left by 1; trial-subtract the divisor from rem; if there is no borrow, keep the difference and set the quotient LSB to 1.
  - When counter reaches 1 at an edge, the next state is FIX. RUN spans edges E1..E32.
- FIX (edge E33):
  - Apply sign correction:
    - MULT: negate the 64-bit product if the operand signs differ.
    - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI/LO. Busy=0 and Done=1 after E33; Done=0 after E34; FSM returns to IDLE.
- Latency: Start sampled at E0 gives the result visible after E33, i.e. 33 cycles, with Busy high for exactly 33 cycles. A new Start is accepted at E34 at the earliest; back-to-back requests are allowed in the Done cycle.
- Arithmetic:
  - Truncating division: quotient rounds toward zero.
  - Signed overflow −2^31 / −1 gives LO=32'h80000000, HI=0.
  - Divide by zero is not trapped and completes with normal latency: HI=A (unmodified dividend), LO=32'hFFFFFFFF, for both DIV and DIVU.
- MTHI/MTLO:
  - In IDLE, write on the edge with zero latency and no Done pulse.
  - MtHi and MtLo may both be high in the same cycle; both registers are then written.
- Simultaneous events:
  - Start together with MtHi/MtLo in IDLE: Start wins and the Mt writes are dropped.
  - Start, MtHi or MtLo while Busy=1: ignored, with no effect on the running operation or on HI/LO.
  - Start with Op changing during RUN: no effect, because the operation is latched at E0.
- HI/LO hold their old values throughout RUN. They change only in FIX, on a Mt write, or on reset.

Test Plan:
- Reset, then MULT A=32'hFFFFFFFD (−3), B=5 -> Busy high 33 cycles; Done pulses once; HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
- MULTU A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001. Same operands with MULT -> HI=0, LO=1.
- DIV A=−7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU A=100, B=7 -> LO=14, HI=2. DIV A=32'h80000000, B=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- DIVU A=1234, B=0 -> after 33 cycles HI=1234, LO=32'hFFFFFFFF.
- IDLE: MtHi=1, Wdata=32'hA5A5A5A5 -> HI=32'hA5A5A5A5 next cycle, no Done. During RUN, Start and MtLo pulsed -> ignored; LO holds its old value until FIX.
- Assert RST=0 asynchronously at RUN cycle 10 -> HI=LO=0, Busy=0, Done=0 immediately. After release, a fresh MULTU 3*4 -> LO=12, HI=0 with full 33-cycle latency.
